hpi_target: RTL
===============

Name: hpi_target

Overview:
- Chip-side responder for the 4-register Host Port Interface (HPI) bus that the NIOS-side hpi_io_intf drives.
- Decodes OTG_CS_N/RD_N/WR_N/ADDR and implements DATA, MAILBOX, ADDRESS and STATUS registers over an internal word RAM, with address auto-increment.
- Provides a device-side mailbox port and drives OTG_INT.
- Used as a synthesizable stand-in for the EZ-OTG chip in simulation and on-board loopback builds.

Parameters:
- MEM_AW, 12, word-address width of internal RAM (2^MEM_AW x 16-bit words).
- RD_LAT, 1, Clk cycles from read strobe sample to OTG_DATA driven (1..4).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- OTG_DATA  inout  16  HPI data bus; driven only during reads, else 'z.
- OTG_ADDR  in  2  register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- OTG_CS_N  in  1  chip select, active low.
- OTG_RD_N  in  1  read strobe, active low.
- OTG_WR_N  in  1  write strobe, active low.
- OTG_RST_N  in  1  host soft reset, active low.
- OTG_INT  out  1  interrupt to host, active high.
- dev_mbx_in_data  out  16  last mailbox word written by host.
- dev_mbx_in_valid  out  1  host mailbox word pending.
- dev_mbx_in_ack  in  1  device consumes pending word.
- dev_mbx_out_data  in  16  device-to-host mailbox word.
- dev_mbx_out_wr  in  1  load dev_mbx_out_data; sets out-full.

Behaviour:
- All bus inputs are sampled on posedge Clk; no combinational path from inputs to OTG_DATA.
- Access start = first cycle with CS_N=0 and (RD_N=0 xor WR_N=0), following a cycle where that condition was false.
- Access end = first cycle the condition goes false.
- Write: data and register are captured at access start.
  - DATA: mem[addr_reg[MEM_AW:1]] <= OTG_DATA.
  - MAILBOX: mbx_in <= data; mbx_in_full <= 1.
  - ADDRESS: addr_reg <= data.
  - STATUS: read-only, write ignored.
- Read: register is latched at access start. OTG_DATA is driven RD_LAT cycles later and held until access end; it returns to 'z the cycle after access end.
  - DATA: mem word.
  - MAILBOX: mbx_out; clears mbx_out_full at access end.
  - ADDRESS: addr_reg.
  - STATUS: {14'b0, mbx_out_full, mbx_in_full}.
- Auto-increment: addr_reg <= addr_reg + 2 at access end of every DATA read or write. Wraps 16'hFFFE -> 16'h0000. RAM index ignores addr_reg bits above MEM_AW and bit 0.
- Reads need a registered (one-cycle) RAM, so RD_LAT >= 1.
- If RD_N and WR_N are both low with CS_N=0: no access, no state change, OTG_DATA stays 'z.
- CS_N deasserted mid-read ends the access and tristates the bus the next cycle. Deasserted before RD_LAT elapses: data is never driven, but auto-increment still happens.
- Mailbox in:
  - dev_mbx_in_valid = mbx_in_full.
  - dev_mbx_in_ack clears it the next cycle.
  - A host write in the same cycle as ack: the write wins (stays full, new data).
  - A host overwrite while full replaces the data.
- Mailbox out:
  - dev_mbx_out_wr sets mbx_out_full and loads mbx_out.
  - dev_mbx_out_wr in the same cycle as a host MAILBOX read-end: the set wins.
  - OTG_INT = mbx_out_full, registered.
- Reset: addr_reg=0, mbx_in=0, mbx_out=0, both full flags=0, OTG_INT=0, OTG_DATA='z, dev_mbx_in_valid=0, dev_mbx_in_data=0, any in-progress access is abandoned. RAM contents are not cleared.
- OTG_RST_N=0 has the same effect as Reset, except on the RAM (not cleared by either); no access is accepted while it is low.

Optional Feature:
- HPI_COLLISION_CHECK_EN defined:
  - An 8-bit saturating counter increments once per cycle with CS_N=0, RD_N=0 and WR_N=0.
  - It is exposed in STATUS[15:8] and cleared by reset, OTG_RST_N, or any STATUS read at access end.
- Undefined: STATUS[15:8]=0 and no counter logic.

Decomposition:
- Package hpi_pkg:
  - hpi_reg_e enum (HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDRESS=2'd2, HPI_STATUS=2'd3).
  - STATUS bit-index constants.
  - access-state enum (IDLE, WR_ACC, RD_WAIT, RD_DRIVE).
- One sub-module: hpi_target_ram, single-port 16-bit synchronous RAM with registered read, MEM_AW parameter.

Test Plan:
- Write ADDRESS=16'h1000, write DATA 16'hBEEF, 16'hCAFE -> ADDRESS reads 16'h1004; rewrite ADDRESS=16'h1000, two DATA reads return 16'hBEEF then 16'hCAFE.
- Host writes MAILBOX 16'h0051 -> dev_mbx_in_valid=1 and data=16'h0051, STATUS=16'h0001; dev ack -> valid=0 the next cycle, STATUS=16'h0000.
- dev_mbx_out_wr with 16'h00A5 -> OTG_INT=1 within 1 cycle, STATUS[1]=1; host MAILBOX read returns 16'h00A5 and OTG_INT=0 after access end.
- ADDRESS=16'hFFFE, DATA write -> ADDRESS reads 16'h0000.
- Reset (and separately OTG_RST_N=0) mid-read -> OTG_DATA='z the next cycle, addr_reg=0, previously written RAM word still readable.
- With HPI_COLLISION_CHECK_EN: hold RD_N=WR_N=CS_N=0 for 300 cycles -> STATUS[15:8]=8'hFF, no RAM or register change; that STATUS read clears the field to 0 on the following read.

Source files
------------

// File: rtl/hpi_pkg.sv
// hpi_pkg: shared types and constants for the HPI target slice.
//   hpi_reg_e     - register select decoded from OTG_ADDR
//   acc_state_e   - host access sequencer states
//   STAT_*        - bit positions inside the STATUS register
package hpi_pkg;

    typedef enum logic [1:0] {
        HPI_DATA    = 2'd0,
        HPI_MAILBOX = 2'd1,
        HPI_ADDRESS = 2'd2,
        HPI_STATUS  = 2'd3
    } hpi_reg_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ACC   = 2'd1,
        RD_WAIT  = 2'd2,
        RD_DRIVE = 2'd3
    } acc_state_e;

    localparam int STAT_IN_FULL  = 0;
    localparam int STAT_OUT_FULL = 1;
    localparam int STAT_COLL_LSB = 8;
    localparam int STAT_COLL_MSB = 15;

endpackage

// File: rtl/hpi_target_ram.sv
// hpi_target_ram: single-port 16-bit word RAM, synchronous write and
// registered read (read data appears the cycle after the address).
//   Clk    - clock
//   we     - write enable
//   addr   - word address (MEM_AW bits)
//   wdata  - write data
//   rdata  - registered read data (old contents on a same-cycle write)
module hpi_target_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**MEM_AW];

    // No reset: RAM contents deliberately survive both reset sources.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/hpi_target.sv
// hpi_target: chip-side responder for the 4-register Host Port Interface.
// Implements DATA / MAILBOX / ADDRESS / STATUS over an internal word RAM
// with address auto-increment, a device-side mailbox port and OTG_INT.
//
// Parameters:
//   MEM_AW - word-address width of the RAM (2^MEM_AW x 16), at most 15
//   RD_LAT - cycles from read-strobe sample to OTG_DATA driven (1..4)
//
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   OTG_DATA              - bidirectional data, driven only during reads
//   OTG_ADDR              - register select
//   OTG_CS_N/RD_N/WR_N    - active-low chip select and strobes
//   OTG_RST_N             - active-low host soft reset
//   OTG_INT               - interrupt to host (device mailbox full)
//   dev_mbx_in_data/valid - host-to-device mailbox word and pending flag
//   dev_mbx_in_ack        - device consumes the pending word
//   dev_mbx_out_data/wr   - device-to-host mailbox word and load strobe
//
// Build option: define HPI_COLLISION_CHECK_EN to add the 8-bit saturating
// RD/WR collision counter reported in STATUS[15:8].
module hpi_target
    import hpi_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    inout  wire  [15:0] OTG_DATA,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_CS_N,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_RST_N,
    output logic        OTG_INT,
    output logic [15:0] dev_mbx_in_data,
    output logic        dev_mbx_in_valid,
    input  logic        dev_mbx_in_ack,
    input  logic [15:0] dev_mbx_out_data,
    input  logic        dev_mbx_out_wr
);

    logic        bus_rd;
    logic        bus_wr;
    logic        acc_cond;
    logic        cond_prev;
    logic        acc_start;
    logic        host_rst;

    acc_state_e  state;
    acc_state_e  state_next;
    logic        drive_load;
    logic        acc_end;
    logic        rd_end;

    hpi_reg_e    acc_reg;
    logic [2:0]  lat_cnt;
    logic [15:0] addr_reg;
    logic [15:0] mbx_in;
    logic [15:0] mbx_out;
    logic        mbx_in_full;
    logic        mbx_out_full;
    logic        drive_en;
    logic [15:0] drive_data;
    logic [15:0] rd_value;
    logic [15:0] status_word;

    logic              ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [15:0]       ram_rdata;

    // Both strobes low is a collision, not an access, so it ends any
    // access in progress and never starts one.
    assign bus_rd    = !OTG_CS_N && !OTG_RD_N &&  OTG_WR_N;
    assign bus_wr    = !OTG_CS_N &&  OTG_RD_N && !OTG_WR_N;
    assign acc_cond  = bus_rd || bus_wr;
    assign acc_start = acc_cond && !cond_prev;
    assign host_rst  = Reset || !OTG_RST_N;

    // Byte address in addr_reg; the RAM is word indexed.
    assign ram_addr = addr_reg[MEM_AW:1];
    assign ram_we   = !host_rst && acc_start && bus_wr &&
                      (hpi_reg_e'(OTG_ADDR) == HPI_DATA);

    hpi_target_ram #(.MEM_AW(MEM_AW)) u_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (OTG_DATA),
        .rdata (ram_rdata)
    );

`ifdef HPI_COLLISION_CHECK_EN
    logic [7:0] coll_cnt;

    // Saturating count of cycles with both strobes low under chip select;
    // a STATUS read clears it once the host has seen the value.
    always_ff @(posedge Clk) begin
        if (host_rst) begin
            coll_cnt <= '0;
        end else if (rd_end && acc_reg == HPI_STATUS) begin
            coll_cnt <= '0;
        end else if (!OTG_CS_N && !OTG_RD_N && !OTG_WR_N && coll_cnt != 8'hFF) begin
            coll_cnt <= coll_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        status_word                = '0;
        status_word[STAT_IN_FULL]  = mbx_in_full;
        status_word[STAT_OUT_FULL] = mbx_out_full;
`ifdef HPI_COLLISION_CHECK_EN
        status_word[STAT_COLL_MSB:STAT_COLL_LSB] = coll_cnt;
`endif
    end

    always_comb begin
        rd_value = ram_rdata;
        case (acc_reg)
            HPI_DATA:    rd_value = ram_rdata;
            HPI_MAILBOX: rd_value = mbx_out;
            HPI_ADDRESS: rd_value = addr_reg;
            HPI_STATUS:  rd_value = status_word;
            default:     rd_value = ram_rdata;
        endcase
    end

    // Access sequencer: reads wait RD_LAT cycles (covering the RAM's
    // registered read) before loading the output register.
    always_comb begin
        state_next = state;
        drive_load = 1'b0;
        acc_end    = 1'b0;
        case (state)
            IDLE: begin
                if (acc_start) begin
                    state_next = bus_wr ? WR_ACC : RD_WAIT;
                end
            end
            WR_ACC, RD_DRIVE: begin
                if (!acc_cond) begin
                    state_next = IDLE;
                    acc_end    = 1'b1;
                end
            end
            RD_WAIT: begin
                if (!acc_cond) begin
                    state_next = IDLE;
                    acc_end    = 1'b1;
                end else if (lat_cnt == 3'(RD_LAT)) begin
                    state_next = RD_DRIVE;
                    drive_load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_end = acc_end && (state == RD_WAIT || state == RD_DRIVE);

    // cond_prev keeps tracking the bus during reset so a strobe still held
    // from before the reset cannot restart an access when reset releases.
    always_ff @(posedge Clk) begin
        if (host_rst) begin
            state        <= IDLE;
            cond_prev    <= acc_cond;
            acc_reg      <= HPI_DATA;
            lat_cnt      <= '0;
            addr_reg     <= '0;
            mbx_in       <= '0;
            mbx_out      <= '0;
            mbx_in_full  <= 1'b0;
            mbx_out_full <= 1'b0;
            drive_en     <= 1'b0;
            drive_data   <= '0;
        end else begin
            state     <= state_next;
            cond_prev <= acc_cond;

            if (acc_start) begin
                acc_reg <= hpi_reg_e'(OTG_ADDR);
                lat_cnt <= 3'd1;
            end else if (state == RD_WAIT && !drive_load) begin
                lat_cnt <= lat_cnt + 3'd1;
            end

            if (drive_load) begin
                drive_en   <= 1'b1;
                drive_data <= rd_value;
            end else if (acc_end) begin
                drive_en <= 1'b0;
            end

            if (acc_start && bus_wr && hpi_reg_e'(OTG_ADDR) == HPI_ADDRESS) begin
                addr_reg <= OTG_DATA;
            end else if (acc_end && acc_reg == HPI_DATA) begin
                addr_reg <= addr_reg + 16'd2;
            end

            // A host write in the same cycle as the device ack wins.
            if (acc_start && bus_wr && hpi_reg_e'(OTG_ADDR) == HPI_MAILBOX) begin
                mbx_in      <= OTG_DATA;
                mbx_in_full <= 1'b1;
            end else if (dev_mbx_in_ack) begin
                mbx_in_full <= 1'b0;
            end

            // A device load in the same cycle as a host read-end wins.
            if (dev_mbx_out_wr) begin
                mbx_out      <= dev_mbx_out_data;
                mbx_out_full <= 1'b1;
            end else if (rd_end && acc_reg == HPI_MAILBOX) begin
                mbx_out_full <= 1'b0;
            end
        end
    end

    assign OTG_DATA         = drive_en ? drive_data : 16'hzzzz;
    assign OTG_INT          = mbx_out_full;
    assign dev_mbx_in_data  = mbx_in;
    assign dev_mbx_in_valid = mbx_in_full;

endmodule
